rr_job_scheduler: RTL and testbench

Round-robin job scheduler that shares a single read/activate processing datapath among `N_REQ` requesters. It arbitrates pending requests, sequences the shared datapath through a one-cycle read strobe followed by an activate phase, and releases the datapath on the datapath's `done` or on a timeout. It sits between the requester ports and the existing read/activate controller path, and replaces direct `en` drive of that path.

---
 rtl/sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/rr_job_scheduler.sv | 135 +++++++++++++
 tb/tb_rr_job_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and constants for the round-robin job scheduler.
// Imported by the scheduler top module.
package sched_pkg;

    localparam int JOB_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        ACTIVE,
        RELEASE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr, wrapping modulo N_REQ.
// Built as a double-width masked priority encoder.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDW-1:0]   pick_id,
    output logic             any
);

    localparam int SW = IDW + 1;

    logic [2*N_REQ-1:0] masked;
    logic [SW-1:0]      sel;

    always_comb begin
        // The upper copy is never masked, so requests below ptr are still found after the wrap.
        masked = {req, req} & ({(2*N_REQ){1'b1}} << ptr);
        // NOTE: give every always_comb output a default before any conditional write, so no latch is inferred.
        sel = '0;
        for (int i = 2*N_REQ-1; i >= 0; i--) begin
            if (masked[i]) begin
                sel = SW'(i);
            end
        end
        pick_id = (sel >= SW'(N_REQ)) ? IDW'(sel - SW'(N_REQ)) : IDW'(sel);
        any     = |req;
        pick    = any ? (N_REQ'(1) << pick_id) : '0;
    end

endmodule

// File: rtl/rr_job_scheduler.sv
// Round-robin job scheduler: grants the shared read/activate datapath to one requester,
// sequences a single read strobe and an activate phase, and releases on done or timeout.
module rr_job_scheduler
    import sched_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 255,
    localparam int IDW     = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic                 done,
    output logic [N_REQ-1:0]     grant,
    output logic [IDW-1:0]       gnt_id,
    output logic                 rd,
    output logic                 act,
    output logic                 busy,
    output logic                 tmo_err,
    output logic [JOB_CNT_W-1:0] job_cnt
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    state_e               state_q,   state_d;
    logic [N_REQ-1:0]     grant_q,   grant_d;
    logic [IDW-1:0]       gnt_id_q,  gnt_id_d;
    logic [IDW-1:0]       ptr_q,     ptr_d;
    logic [TCW-1:0]       tcnt_q,    tcnt_d;
    logic [JOB_CNT_W-1:0] job_cnt_q, job_cnt_d;
    logic                 tmo_err_q, tmo_err_d;
    logic                 rd_q,      rd_d;
    logic                 act_q,     act_d;
    logic                 busy_q,    busy_d;

    logic [N_REQ-1:0]     arb_pick;
    logic [IDW-1:0]       arb_pick_id;
    logic                 arb_any;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arbiter (
        .req     (req),
        .ptr     (ptr_q),
        .pick    (arb_pick),
        .pick_id (arb_pick_id),
        .any     (arb_any)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        tcnt_d    = tcnt_q;
        job_cnt_d = job_cnt_q;
        tmo_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d  = arb_pick;
                    gnt_id_d = arb_pick_id;
                    state_d  = READ;
                end
            end
            READ: begin
                tcnt_d  = '0;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                // done has priority over a timeout landing in the same cycle.
                if (done) begin
                    job_cnt_d = job_cnt_q + 1'b1;
                    grant_d   = '0;
                    state_d   = RELEASE;
                end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
                    tmo_err_d = 1'b1;
                    grant_d   = '0;
                    state_d   = RELEASE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            RELEASE: begin
                ptr_d   = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobe outputs are registered copies of the next-state decode, so they align with state_q.
        rd_d   = (state_d == READ);
        act_d  = (state_d == ACTIVE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            tcnt_q    <= '0;
            job_cnt_q <= '0;
            tmo_err_q <= 1'b0;
            rd_q      <= 1'b0;
            act_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            grant_q   <= grant_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            tcnt_q    <= tcnt_d;
            job_cnt_q <= job_cnt_d;
            tmo_err_q <= tmo_err_d;
            rd_q      <= rd_d;
            act_q     <= act_d;
            busy_q    <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign gnt_id  = gnt_id_q;
    assign rd      = rd_q;
    assign act     = act_q;
    assign busy    = busy_q;
    assign tmo_err = tmo_err_q;
    assign job_cnt = job_cnt_q;

endmodule

// File: tb/tb_rr_job_scheduler.sv
// Self-checking bench for rr_job_scheduler: vector table, directed corner sequences,
// and randomized traffic compared against a job-level reference model.
module tb_rr_job_scheduler;

    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic        done;
    logic [3:0]  grant;
    logic [1:0]  gnt_id;
    logic        rd;
    logic        act;
    logic        busy;
    logic        tmo_err;
    logic [15:0] job_cnt;

    int n_pass;
    int n_total;

    rr_job_scheduler #(
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .gnt_id  (gnt_id),
        .rd      (rd),
        .act     (act),
        .busy    (busy),
        .tmo_err (tmo_err),
        .job_cnt (job_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  req;
        logic        done;
        logic [3:0]  grant;
        logic [1:0]  id;
        logic        rd;
        logic        act;
        logic        busy;
        logic        tmo;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [3:0] r, input logic d, input logic [3:0] g,
                                input logic [1:0] id, input logic rd_e, input logic act_e,
                                input logic busy_e, input logic tmo_e, input logic [15:0] cnt);
        vec_t v;
        v.req = r; v.done = d; v.grant = g; v.id = id;
        v.rd = rd_e; v.act = act_e; v.busy = busy_e; v.tmo = tmo_e; v.cnt = cnt;
        return v;
    endfunction

    // Output bundle {grant, gnt_id, rd, act, busy, tmo_err, job_cnt}, printed in hex on a mismatch.
    function automatic logic [63:0] pack(input logic [3:0] g, input logic [1:0] id, input logic r,
                                         input logic a, input logic b, input logic t,
                                         input logic [15:0] c);
        return {38'd0, g, id, r, a, b, t, c};
    endfunction

    function automatic logic [63:0] dut_outs();
        return pack(grant, gnt_id, rd, act, busy, tmo_err, job_cnt);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Job-level reference model: a job is the grant cycle, then activate cycles counted by age,
    // then one release cycle.
    bit          m_job;
    bit          m_ended;
    bit          m_tmo;
    int          m_age;
    int          m_owner;
    int          m_ptr;
    logic [15:0] m_cnt;

    task automatic model_reset();
        m_job = 0; m_ended = 0; m_tmo = 0; m_age = 0; m_owner = 0; m_ptr = 0; m_cnt = 16'd0;
    endtask

    function automatic logic [63:0] model_outs();
        logic [3:0] g;
        g = (m_job && !m_ended) ? (4'b0001 << m_owner) : 4'b0000;
        return pack(g, 2'(m_owner), m_job && m_age == 0, m_job && m_age >= 1 && !m_ended,
                    m_job, m_tmo, m_cnt);
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d);
        bit found;
        m_tmo = 0;
        if (!m_job) begin
            found = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && r[(m_ptr + k) % N_REQ]) begin
                    m_owner = (m_ptr + k) % N_REQ;
                    found   = 1;
                end
            end
            if (found) begin
                m_job = 1; m_age = 0; m_ended = 0;
            end
        end else if (m_ended) begin
            m_ptr = (m_owner + 1) % N_REQ;
            m_job = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (d) begin
            m_cnt   = m_cnt + 16'd1;
            m_ended = 1;
        end else if (m_age == TIMEOUT) begin
            m_ended = 1;
            m_tmo   = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'h0; done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Runs one job from IDLE; done is driven in activate cycle done_at (0 = never).
    task automatic run_job(input logic [3:0] r, input int done_at, output int act_len,
                           output int tmo_n, output logic [3:0] gnt_seen,
                           output logic [3:0] gnt_at_tmo, output logic fin);
        act_len = 0; tmo_n = 0; gnt_at_tmo = 4'hF;
        req = r; done = 1'b0;
        @(negedge clk);
        req = 4'h0;
        gnt_seen = grant;
        for (int c = 0; c < TIMEOUT + 6; c++) begin
            if (act) act_len++;
            done = act && (act_len == done_at);
            @(negedge clk);
            if (tmo_err) begin
                tmo_n++;
                gnt_at_tmo = grant;
            end
            if (!busy) break;
        end
        done = 1'b0;
        fin  = !busy;
    endtask

    int         act_len, tmo_n, act_run, last_rd, overlap, spacing_bad;
    logic [3:0] gseen, gtmo, r;
    logic       fin, d;
    int         grants[$];

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; req = 4'h0; done = 1'b0;

        // Single job, done in the third activate cycle, then a follow-up grant proving ptr moved to 2.
        vecs[0]  = mk(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0);
        vecs[1]  = mk(4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[2]  = mk(4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[3]  = mk(4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        vecs[4]  = mk(4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[5]  = mk(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
        vecs[6]  = mk(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
        vecs[7]  = mk(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
        vecs[8]  = mk(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
        vecs[9]  = mk(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
        vecs[10] = mk(4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

        do_reset();
        check("reset outputs", dut_outs(), 64'd0);
        foreach (vecs[i]) begin
            req = vecs[i].req; done = vecs[i].done;
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_outs(),
                  pack(vecs[i].grant, vecs[i].id, vecs[i].rd, vecs[i].act, vecs[i].busy,
                       vecs[i].tmo, vecs[i].cnt));
        end
        req = 4'h0; done = 1'b0;

        // Round robin with all requesters active and done in the first activate cycle.
        do_reset();
        req = 4'hF;
        act_run = 0; last_rd = -1; overlap = 0; spacing_bad = 0;
        grants.delete();
        for (int c = 0; c < 100 && grants.size() < 5; c++) begin
            @(negedge clk);
            if (rd && act) overlap++;
            if (rd) begin
                grants.push_back(int'(gnt_id));
                if (last_rd >= 0 && c - last_rd != 4) spacing_bad++;
                last_rd = c;
            end
            act_run = act ? act_run + 1 : 0;
            done = (act_run == 1);
        end
        req = 4'h0; done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr grant %0d", i),
                  (i < grants.size()) ? 64'(grants[i]) : 64'hFFFF, 64'(i % N_REQ));
        end
        check("rr rd/act overlap", 64'(overlap), 64'd0);
        check("rr grant spacing", 64'(spacing_bad), 64'd0);

        // Timeout with done never asserted.
        do_reset();
        run_job(4'b0001, 0, act_len, tmo_n, gseen, gtmo, fin);
        check("tmo grant", 64'(gseen), 64'h1);
        check("tmo act length", 64'(act_len), 64'(TIMEOUT));
        check("tmo pulses", 64'(tmo_n), 64'd1);
        check("tmo grant at pulse", 64'(gtmo), 64'h0);
        check("tmo job_cnt", 64'(job_cnt), 64'd0);
        check("tmo idle after", {63'd0, fin}, 64'd1);

        // done in the same activate cycle that would time out.
        run_job(4'b0001, TIMEOUT, act_len, tmo_n, gseen, gtmo, fin);
        check("sim act length", 64'(act_len), 64'(TIMEOUT));
        check("sim tmo pulses", 64'(tmo_n), 64'd0);
        check("sim job_cnt", 64'(job_cnt), 64'd1);

        // Asynchronous reset mid-activate, after ptr has moved to 3.
        do_reset();
        run_job(4'b0100, 1, act_len, tmo_n, gseen, gtmo, fin);
        check("pre-reset job_cnt", 64'(job_cnt), 64'd1);
        req = 4'b1000;
        @(negedge clk);
        req = 4'h0;
        repeat (2) @(negedge clk);
        check("pre-reset act", {63'd0, act}, 64'd1);
        #2 rst = 1'b1;
        #1 check("async reset outputs", dut_outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1010;
        @(negedge clk);
        check("post-reset grant", dut_outs(), pack(4'b0010, 2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0));
        req = 4'h0;

        // Counter wrap from a preloaded value.
        do_reset();
        force dut.job_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.job_cnt_q;
        @(negedge clk);
        check("wrap preload", 64'(job_cnt), 64'hFFFE);
        run_job(4'b0001, 1, act_len, tmo_n, gseen, gtmo, fin);
        check("wrap ffff", 64'(job_cnt), 64'hFFFF);
        run_job(4'b0010, 1, act_len, tmo_n, gseen, gtmo, fin);
        check("wrap zero", 64'(job_cnt), 64'h0);
        check("wrap no tmo", 64'(tmo_n), 64'd0);
        check("wrap grant", 64'(gseen), 64'h2);

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            d = ($urandom_range(0, 3) == 0);
            req = r; done = d;
            model_step(r, d);
            @(negedge clk);
            check($sformatf("rand c%0d", c), dut_outs(), model_outs());
        end
        req = 4'h0; done = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
